btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
- Upstream input-conditioning stage between the raw board push-buttons and the combinational button-to-LED logic.
- Synchronises each asynchronous button to the system clock.
- Filters contact bounce with a per-channel stability counter.
- Presents a clean level per button plus single-cycle press/release strobes for later counter/FSM labs.

Parameters:
- N_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a new synchronised level must persist before acceptance (10 ms at 100 MHz); legal range >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), derived localparam, per-channel counter width; not overridable.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn  input  N_BTN  raw asynchronous button levels, active-high.
- btn_db  output  N_BTN  debounced level, registered.
- btn_rise  output  N_BTN  one-cycle strobe when btn_db goes 0->1.
- btn_fall  output  N_BTN  one-cycle strobe when btn_db goes 1->0.

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: sync flops, counters, btn_db, btn_rise and btn_fall are all 0.
- Synchroniser: per channel, a 2-flop chain btn -> s1 -> s2. s2 is the only value the filter examines.
- Filter, per channel, evaluated each edge when reset = 0:
  - s2 == btn_db: counter <= 0; no change.
  - s2 != btn_db and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - s2 != btn_db and counter == DEBOUNCE_CYCLES-1: btn_db <= s2; counter <= 0; strobe set.
- Strobes:
  - btn_rise[i] = 1 for exactly the one cycle in which btn_db[i] has just become 1 (registered with btn_db, same edge).
  - btn_fall[i] likewise for the 0 transition.
  - Otherwise both are 0.
  - rise and fall of one channel are never high together.
- Latency: if btn[i] holds a new level from the edge that first samples it (edge 0), btn_db[i] and its strobe update at edge DEBOUNCE_CYCLES+1.
- Glitch rejection:
  - Any return of s2 to btn_db before the count completes clears the counter.
  - Pulses shorter than DEBOUNCE_CYCLES synchronised cycles produce no output change.
  - Bounce restarts the count from 0 at each reversal.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous strobes.
- DEBOUNCE_CYCLES = 1: a single differing s2 cycle is accepted at the next edge.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Reset mid-count:
  - All state clears immediately at the reset edge, including the synchronisers.
  - A button still held after reset deasserts is re-debounced from scratch: btn_db rises DEBOUNCE_CYCLES+2 edges after the first edge with reset = 0. The first edge re-samples the button into s1.
  - One btn_rise is produced.
- No combinational path from btn to any output.

Decomposition:
- Shared package board_io_pkg:
  - N_BTN default (4).
  - CLK_HZ (100000000).
  - DEBOUNCE_MS (10).
  - Derived default DEBOUNCE_CYCLES constant, so later lab top-levels reuse the same values.
- One natural sub-module, debounce_ch:
  - Single channel: 2-flop synchroniser, counter, level and strobe registers.
  - Instantiated N_BTN times via generate.
- btn_debounce itself holds only the generate loop and port bundling.

Test Plan (DEBOUNCE_CYCLES = 4 for all scenarios):
- Reset with btn = 4'b1111: btn_db, btn_rise and btn_fall are 0 while reset = 1. After release, btn_db = 4'b1111 at the 6th edge with reset = 0, and btn_rise = 4'b1111 for that one cycle.
- btn[0] 0->1 first sampled at edge 0 and held: btn_db[0] = 1 and btn_rise[0] = 1 at edge 5 only. btn_rise[0] = 0 at edge 6. Other channels stay 0.
- Glitch: btn[1] high for 3 cycles, then low: btn_db[1] stays 0 throughout; no strobes on any channel.
- Bounce: btn[2] toggles every cycle for 6 cycles, then stays 1 from edge t: btn_db[2] rises at edge t+5, with exactly one btn_rise[2] pulse and no btn_fall[2].
- Release: btn[0] debounced high, then 1->0 at edge t and held: btn_db[0] = 0 and btn_fall[0] = 1 at edge t+5 for one cycle. btn_rise[0] stays 0.
- Simultaneous events and mid-count reset:
  - All four buttons pressed at the same edge: btn_rise = 4'b1111 for one cycle.
  - Reset asserted 2 cycles into a count with the button held: counter and btn_db stay 0.
  - After reset deasserts: btn_db rises at the 6th edge with reset = 0.

Source files
------------

// File: rtl/board_io_pkg.sv
// Board-level I/O constants shared by the button conditioning stage and later lab tops.
// Changing CLK_HZ or DEBOUNCE_MS retunes every debouncer that takes the package default.
package board_io_pkg;

  localparam int DEF_N_BTN   = 4;
  localparam int CLK_HZ      = 100_000_000;
  localparam int DEBOUNCE_MS = 10;

  // 10 ms at 100 MHz gives 1_000_000 stable cycles before a new level is accepted.
  localparam int DEF_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level and
// single-cycle rise/fall strobes, all registered on the same edge.
module debounce_ch
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic btn_db,
  output logic btn_rise,
  output logic btn_fall
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;
  logic             r_rise;
  logic             r_fall;

  // Synchronise, then accept s2 only after it has differed from the level for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= btn;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db   <= r_s2;
        r_cnt  <= '0;
        r_rise <= r_s2;
        r_fall <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign btn_db   = r_db;
  assign btn_rise = r_rise;
  assign btn_fall = r_fall;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioning front end: N_BTN independent debounce channels
// producing clean levels plus press/release strobes.
module btn_debounce
  import board_io_pkg::*;
#(
  parameter int N_BTN           = DEF_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall
);

  logic [N_BTN-1:0] w_db;
  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] w_fall;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .btn      (btn[g]),
      .btn_db   (w_db[g]),
      .btn_rise (w_rise[g]),
      .btn_fall (w_fall[g])
    );
  end

  assign btn_db   = w_db;
  assign btn_rise = w_rise;
  assign btn_fall = w_fall;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce with DEBOUNCE_CYCLES = 4.
module tb_btn_debounce;

  localparam int NB = 4;

  logic          clk;
  logic          reset;
  logic [NB-1:0] btn;
  logic [NB-1:0] btn_db;
  logic [NB-1:0] btn_rise;
  logic [NB-1:0] btn_fall;

  int n_cmp;
  int n_err;

  btn_debounce #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .btn_db   (btn_db),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn   = 4'b0000;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [NB-1:0] e_db;
    logic [NB-1:0] e_rise;
    reset = 1'b1;
    btn   = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({btn_db, btn_rise, btn_fall} !== 12'h000) begin
        n_err++;
        $display("FAIL reset_hold k=%0d got db=%b rise=%b fall=%b want all 0", k, btn_db, btn_rise, btn_fall);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      e_db   = (k >= 6) ? 4'b1111 : 4'b0000;
      e_rise = (k == 6) ? 4'b1111 : 4'b0000;
      n_cmp++;
      if (btn_db !== e_db || btn_rise !== e_rise || btn_fall !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_release edge=%0d got db=%b rise=%b fall=%b want db=%b rise=%b fall=0000",
                 k, btn_db, btn_rise, btn_fall, e_db, e_rise);
      end
    end
  endtask

  task automatic test_press();
    logic [NB-1:0] e_db;
    logic [NB-1:0] e_rise;
    do_reset();
    btn = 4'b0001;
    for (int k = 0; k <= 6; k++) begin
      step();
      e_db   = (k >= 5) ? 4'b0001 : 4'b0000;
      e_rise = (k == 5) ? 4'b0001 : 4'b0000;
      n_cmp++;
      if (btn_db !== e_db || btn_rise !== e_rise || btn_fall !== 4'b0000) begin
        n_err++;
        $display("FAIL press edge=%0d got db=%b rise=%b fall=%b want db=%b rise=%b fall=0000",
                 k, btn_db, btn_rise, btn_fall, e_db, e_rise);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    btn = 4'b0010;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 2) btn = 4'b0000;
      n_cmp++;
      if ({btn_db, btn_rise, btn_fall} !== 12'h000) begin
        n_err++;
        $display("FAIL glitch edge=%0d got db=%b rise=%b fall=%b want all 0", k, btn_db, btn_rise, btn_fall);
      end
    end
  endtask

  task automatic test_bounce();
    logic [NB-1:0] e_db;
    logic [NB-1:0] e_rise;
    int            n_rise;
    do_reset();
    n_rise = 0;
    for (int k = 0; k < 6; k++) begin
      btn = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      step();
      n_cmp++;
      if ({btn_db, btn_rise, btn_fall} !== 12'h000) begin
        n_err++;
        $display("FAIL bounce_toggle k=%0d got db=%b rise=%b fall=%b want all 0", k, btn_db, btn_rise, btn_fall);
      end
    end
    btn = 4'b0100;
    for (int k = 0; k <= 8; k++) begin
      step();
      if (btn_rise[2]) n_rise++;
      e_db   = (k >= 5) ? 4'b0100 : 4'b0000;
      e_rise = (k == 5) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (btn_db !== e_db || btn_rise !== e_rise || btn_fall !== 4'b0000) begin
        n_err++;
        $display("FAIL bounce_settle t+%0d got db=%b rise=%b fall=%b want db=%b rise=%b fall=0000",
                 k, btn_db, btn_rise, btn_fall, e_db, e_rise);
      end
    end
    n_cmp++;
    if (n_rise != 1) begin
      n_err++;
      $display("FAIL bounce_rise_count got %0d want 1", n_rise);
    end
  endtask

  task automatic test_release();
    logic [NB-1:0] e_db;
    logic [NB-1:0] e_fall;
    do_reset();
    btn = 4'b0001;
    for (int k = 0; k < 6; k++) step();
    n_cmp++;
    if (btn_db !== 4'b0001) begin
      n_err++;
      $display("FAIL release_pre got db=%b want 0001", btn_db);
    end
    btn = 4'b0000;
    for (int k = 0; k <= 6; k++) begin
      step();
      e_db   = (k < 5) ? 4'b0001 : 4'b0000;
      e_fall = (k == 5) ? 4'b0001 : 4'b0000;
      n_cmp++;
      if (btn_db !== e_db || btn_fall !== e_fall || btn_rise !== 4'b0000) begin
        n_err++;
        $display("FAIL release t+%0d got db=%b rise=%b fall=%b want db=%b rise=0000 fall=%b",
                 k, btn_db, btn_rise, btn_fall, e_db, e_fall);
      end
    end
  endtask

  task automatic test_simul_midreset();
    logic [NB-1:0] e_db;
    logic [NB-1:0] e_rise;
    do_reset();
    btn = 4'b1111;
    for (int k = 0; k <= 6; k++) begin
      step();
      e_db   = (k >= 5) ? 4'b1111 : 4'b0000;
      e_rise = (k == 5) ? 4'b1111 : 4'b0000;
      n_cmp++;
      if (btn_db !== e_db || btn_rise !== e_rise || btn_fall !== 4'b0000) begin
        n_err++;
        $display("FAIL simul edge=%0d got db=%b rise=%b fall=%b want db=%b rise=%b fall=0000",
                 k, btn_db, btn_rise, btn_fall, e_db, e_rise);
      end
    end
    do_reset();
    btn = 4'b0001;
    for (int k = 0; k < 4; k++) step();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({btn_db, btn_rise, btn_fall} !== 12'h000) begin
        n_err++;
        $display("FAIL midreset_hold k=%0d got db=%b rise=%b fall=%b want all 0", k, btn_db, btn_rise, btn_fall);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      e_db   = (k >= 6) ? 4'b0001 : 4'b0000;
      e_rise = (k == 6) ? 4'b0001 : 4'b0000;
      n_cmp++;
      if (btn_db !== e_db || btn_rise !== e_rise || btn_fall !== 4'b0000) begin
        n_err++;
        $display("FAIL midreset_release edge=%0d got db=%b rise=%b fall=%b want db=%b rise=%b fall=0000",
                 k, btn_db, btn_rise, btn_fall, e_db, e_rise);
      end
    end
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    btn   = 4'b0000;
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_press();
    test_glitch();
    test_bounce();
    test_release();
    test_simul_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
